// File: rtl/debug_dump_uart.sv
// Debug register dumper: sweeps the computer's debug register port and streams
// sync byte 0xA5, all registers and a fetchPC snapshot as one 8N1 UART frame.
module debug_dump_uart #(
  parameter int unsigned CLKS_PER_BIT  = 868,
  parameter int unsigned NUM_REGS      = 16,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] debug_reg_out,
  input  logic [31:0] fetchPC,
  output logic [3:0]  debug_reg_select,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] BIT_LAST    = TW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]    REG_LAST    = 5'(NUM_REGS - 1);
  localparam logic [7:0]    SYNC_BYTE   = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, SELECT, CAPTURE, FINISH
  } state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [SW-1:0] settle_q;
  logic [2:0]    bit_idx_q;
  logic [1:0]    byte_idx_q;
  logic [7:0]    shift_q;
  logic [31:0]   pc_snap_q;
  logic [31:0]   word_snap_q;
  logic [4:0]    reg_idx_q;
  logic          sync_q;
  logic          pc_word_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;

  logic [1:0]    byte_nxt_d;
  logic [7:0]    byte_data_d;
  logic          bit_end_d;

  always_comb begin
    byte_nxt_d  = byte_idx_q - 2'd1;
    byte_data_d = word_snap_q[{byte_nxt_d, 3'b000} +: 8];
    bit_end_d   = (timer_q == BIT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      settle_q    <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      pc_snap_q   <= '0;
      word_snap_q <= '0;
      reg_idx_q   <= '0;
      sync_q      <= 1'b0;
      pc_word_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            pc_snap_q <= fetchPC;
            busy_q    <= 1'b1;
            shift_q   <= SYNC_BYTE;
            sync_q    <= 1'b1;
            pc_word_q <= 1'b0;
            timer_q   <= '0;
            tx_q      <= 1'b0;
            state_q   <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end_d) begin
            timer_q   <= '0;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
            state_q   <= TX_DATA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        TX_DATA: begin
          if (bit_end_d) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        TX_STOP: begin
          if (bit_end_d) begin
            timer_q <= '0;
            // Next-byte priority: sync -> reg 0, rest of word, PC done, PC word, next reg.
            if (sync_q) begin
              sync_q    <= 1'b0;
              reg_idx_q <= '0;
              settle_q  <= '0;
              state_q   <= SELECT;
            end else if (byte_idx_q != 2'd0) begin
              byte_idx_q <= byte_nxt_d;
              shift_q    <= byte_data_d;
              tx_q       <= 1'b0;
              state_q    <= TX_START;
            end else if (pc_word_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else if (reg_idx_q == REG_LAST) begin
              pc_word_q   <= 1'b1;
              word_snap_q <= pc_snap_q;
              shift_q     <= pc_snap_q[31:24];
              byte_idx_q  <= 2'd3;
              tx_q        <= 1'b0;
              state_q     <= TX_START;
            end else begin
              reg_idx_q <= reg_idx_q + 5'd1;
              settle_q  <= '0;
              state_q   <= SELECT;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        SELECT: begin
          if (settle_q == SETTLE_LAST) begin
            settle_q <= '0;
            state_q  <= CAPTURE;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        CAPTURE: begin
          word_snap_q <= debug_reg_out;
          shift_q     <= debug_reg_out[31:24];
          byte_idx_q  <= 2'd3;
          tx_q        <= 1'b0;
          state_q     <= TX_START;
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign debug_reg_select = reg_idx_q[3:0];
  assign tx               = tx_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
